// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, byte-enable
// constants, port ids and the read-modify-write byte merge.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MERGE  = 2'd2
   } state_e;

   localparam logic [3:0] BE_FULL  = 4'hF;
   localparam logic [3:0] BE_NONE  = 4'h0;
   localparam logic       PORT_CPU = 1'b0;
   localparam logic       PORT_AUX = 1'b1;

   // Byte i comes from new_w when be[i] is set, otherwise from old_w.
   function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                               input logic [31:0] new_w,
                                               input logic [31:0] old_w);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Combinational 2-way arbiter: fixed CPU priority or round-robin on last_grant.
module dm_rr_arb
   import dm_arb_pkg::*;
#(
   parameter bit CPU_PRIO = 1'b1
) (
   input  logic [1:0] eligible_i,
   input  logic       last_grant_i,
   output logic       grant_id_o,
   output logic       grant_valid_o
);

   // Pick a winner among the eligible ports.
   always_comb begin
      grant_id_o    = PORT_CPU;
      grant_valid_o = |eligible_i;
      case (eligible_i)
         2'b01:   grant_id_o = PORT_CPU;
         2'b10:   grant_id_o = PORT_AUX;
         2'b11: begin
            if (CPU_PRIO) begin
               grant_id_o = PORT_CPU;
            end else begin
               grant_id_o = ~last_grant_i;
            end
         end
         default: grant_id_o = PORT_CPU;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory controller: arbitrates M-stage and aux masters and
// sequences reads, full writes and byte-enable read-modify-write.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter bit CPU_PRIO = 1'b1,
   parameter int AW       = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [31:0]   p0_wdata,
   input  logic [3:0]    p0_be,
   output logic          p0_ack,
   output logic [31:0]   p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [31:0]   p1_wdata,
   input  logic [3:0]    p1_be,
   output logic          p1_ack,
   output logic [31:0]   p1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wd,
   output logic          mem_we,
   input  logic [31:0]   mem_rd,
   output logic          busy
);

   state_e        state_q, state_d;
   logic          grant_q, grant_d;
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   merge_q, merge_d;
   logic          p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
   logic [31:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
   logic [1:0]    eligible_s;
   logic          grant_id_s, grant_valid_s;
   logic          unused_addr_lsb_s;

   // A port still seeing its ack cannot be re-granted in that cycle.
   assign eligible_s = {p1_req & ~p1_ack_q, p0_req & ~p0_ack_q};
   assign unused_addr_lsb_s = ^{p0_addr[1:0], p1_addr[1:0]};

   dm_rr_arb #(.CPU_PRIO(CPU_PRIO)) u_arb (
      .eligible_i    (eligible_s),
      .last_grant_i  (last_q),
      .grant_id_o    (grant_id_s),
      .grant_valid_o (grant_valid_s)
   );

   // Next-state and datapath register updates.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      merge_d    = merge_q;
      p0_ack_d   = 1'b0;
      p1_ack_d   = 1'b0;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid_s) begin
               grant_d = grant_id_s;
               last_d  = grant_id_s;
               state_d = ST_ACCESS;
               if (grant_id_s == PORT_AUX) begin
                  we_d    = p1_we;
                  addr_d  = {p1_addr[AW-1:2], 2'b00};
                  wdata_d = p1_wdata;
                  be_d    = p1_be;
               end else begin
                  we_d    = p0_we;
                  addr_d  = {p0_addr[AW-1:2], 2'b00};
                  wdata_d = p0_wdata;
                  be_d    = p0_be;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!we_q) begin
               state_d  = ST_IDLE;
               p0_ack_d = (grant_q == PORT_CPU);
               p1_ack_d = (grant_q == PORT_AUX);
               if (grant_q == PORT_AUX) begin
                  p1_rdata_d = mem_rd;
               end else begin
                  p0_rdata_d = mem_rd;
               end
            end else if ((be_q == BE_FULL) || (be_q == BE_NONE)) begin
               state_d  = ST_IDLE;
               p0_ack_d = (grant_q == PORT_CPU);
               p1_ack_d = (grant_q == PORT_AUX);
            end else begin
               merge_d = mem_rd;
               state_d = ST_MERGE;
            end
         end
         ST_MERGE: begin
            state_d  = ST_IDLE;
            p0_ack_d = (grant_q == PORT_CPU);
            p1_ack_d = (grant_q == PORT_AUX);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; last grant resets to aux so CPU wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= PORT_CPU;
         last_q     <= PORT_AUX;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'h0000_0000;
         be_q       <= 4'h0;
         merge_q    <= 32'h0000_0000;
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
         p0_rdata_q <= 32'h0000_0000;
         p1_rdata_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         merge_q    <= merge_d;
         p0_ack_q   <= p0_ack_d;
         p1_ack_q   <= p1_ack_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   // Memory strobe and data are decoded from state so reset drops them at once.
   always_comb begin
      mem_we = 1'b0;
      mem_wd = 32'h0000_0000;
      case (state_q)
         ST_ACCESS: begin
            mem_wd = wdata_q;
            mem_we = we_q & (be_q == BE_FULL);
         end
         ST_MERGE: begin
            mem_wd = merge_bytes(be_q, wdata_q, merge_q);
            mem_we = 1'b1;
         end
         default: begin
            mem_we = 1'b0;
            mem_wd = 32'h0000_0000;
         end
      endcase
   end

   assign mem_addr = addr_q;
   assign busy     = (state_q != ST_IDLE);
   assign p0_ack   = p0_ack_q;
   assign p1_ack   = p1_ack_q;
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: round-robin instance (a) and CPU-priority
// instance (b) share stimulus, each with its own word memory model.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]  p0_be, p1_be;

   logic        p0_ack_a, p1_ack_a, mem_we_a, busy_a;
   logic [31:0] p0_rdata_a, p1_rdata_a, mem_addr_a, mem_wd_a, mem_rd_a;
   logic        p0_ack_b, p1_ack_b, mem_we_b, busy_b;
   logic [31:0] p0_rdata_b, p1_rdata_b, mem_addr_b, mem_wd_b, mem_rd_b;

   logic [31:0] mem_a [0:63];
   logic [31:0] mem_b [0:63];
   int          we_cnt_a = 0;
   int          we_cnt_b = 0;
   int          checks   = 0;
   int          failures = 0;
   int          snap;

   always #5 clk = ~clk;

   dm_arbiter #(.CPU_PRIO(1'b0), .AW(32)) u_a (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ack(p0_ack_a), .p0_rdata(p0_rdata_a),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ack(p1_ack_a), .p1_rdata(p1_rdata_a),
      .mem_addr(mem_addr_a), .mem_wd(mem_wd_a), .mem_we(mem_we_a), .mem_rd(mem_rd_a),
      .busy(busy_a)
   );

   dm_arbiter #(.CPU_PRIO(1'b1), .AW(32)) u_b (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ack(p0_ack_b), .p0_rdata(p0_rdata_b),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ack(p1_ack_b), .p1_rdata(p1_rdata_b),
      .mem_addr(mem_addr_b), .mem_wd(mem_wd_b), .mem_we(mem_we_b), .mem_rd(mem_rd_b),
      .busy(busy_b)
   );

   assign mem_rd_a = mem_a[mem_addr_a[7:2]];
   assign mem_rd_b = mem_b[mem_addr_b[7:2]];

   always @(posedge clk) begin
      if (mem_we_a) begin
         mem_a[mem_addr_a[7:2]] <= mem_wd_a;
         we_cnt_a <= we_cnt_a + 1;
      end
      if (mem_we_b) begin
         mem_b[mem_addr_b[7:2]] <= mem_wd_b;
         we_cnt_b <= we_cnt_b + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_be = 4'h0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_be = 4'h0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      #3;
      chk("rst_p0_ack", {31'd0, p0_ack_a}, 32'd0);
      chk("rst_p1_ack", {31'd0, p1_ack_a}, 32'd0);
      chk("rst_p0_rdata", p0_rdata_a, 32'h0);
      chk("rst_p1_rdata", p1_rdata_a, 32'h0);
      chk("rst_mem_we", {31'd0, mem_we_a}, 32'd0);
      chk("rst_mem_addr", mem_addr_a, 32'h0);
      chk("rst_mem_wd", mem_wd_a, 32'h0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Full-word write 0xDEADBEEF to 0x10 from port 0
      snap = we_cnt_a;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF; p0_be = 4'hF;
      cyc();
      chk("fw_busy", {31'd0, busy_a}, 32'd1);
      chk("fw_mem_we", {31'd0, mem_we_a}, 32'd1);
      chk("fw_mem_wd", mem_wd_a, 32'hDEADBEEF);
      chk("fw_mem_addr", mem_addr_a, 32'h10);
      chk("fw_no_early_ack", {31'd0, p0_ack_a}, 32'd0);
      cyc();
      chk("fw_ack", {31'd0, p0_ack_a}, 32'd1);
      chk("fw_busy_done", {31'd0, busy_a}, 32'd0);
      chk("fw_mem", mem_a[4], 32'hDEADBEEF);
      chk("fw_we_cycles", snap + 1, we_cnt_a);
      p0_req = 1'b0;
      cyc();
      chk("fw_ack_pulse", {31'd0, p0_ack_a}, 32'd0);

      // Read of 0x13 (low address bits ignored)
      snap = we_cnt_a;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h13; p0_wdata = 32'h0; p0_be = 4'h0;
      cyc();
      chk("rd_mem_addr", mem_addr_a, 32'h10);
      chk("rd_no_we", {31'd0, mem_we_a}, 32'd0);
      cyc();
      chk("rd_ack", {31'd0, p0_ack_a}, 32'd1);
      chk("rd_data", p0_rdata_a, 32'hDEADBEEF);
      p0_req = 1'b0;
      cyc();
      chk("rd_ack_pulse", {31'd0, p0_ack_a}, 32'd0);
      chk("rd_data_hold", p0_rdata_a, 32'hDEADBEEF);
      chk("rd_we_cycles", snap, we_cnt_a);

      // Port 1 full write 0x11223344 to 0x20
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h11223344; p1_be = 4'hF;
      cyc();
      cyc();
      chk("p1fw_ack", {31'd0, p1_ack_a}, 32'd1);
      chk("p1fw_p0_quiet", {31'd0, p0_ack_a}, 32'd0);
      chk("p1fw_mem", mem_a[8], 32'h11223344);
      p1_req = 1'b0;
      cyc();

      // Partial write be=0010; changes after grant must be ignored
      snap = we_cnt_a;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'hAABBCCDD; p1_be = 4'b0010;
      cyc();
      chk("pw_access_no_we", {31'd0, mem_we_a}, 32'd0);
      chk("pw_access_no_ack", {31'd0, p1_ack_a}, 32'd0);
      p1_wdata = 32'h0; p1_be = 4'hF;
      cyc();
      chk("pw_merge_we", {31'd0, mem_we_a}, 32'd1);
      chk("pw_merge_wd", mem_wd_a, 32'h1122CC44);
      chk("pw_merge_no_ack", {31'd0, p1_ack_a}, 32'd0);
      chk("pw_merge_busy", {31'd0, busy_a}, 32'd1);
      cyc();
      chk("pw_ack", {31'd0, p1_ack_a}, 32'd1);
      chk("pw_mem", mem_a[8], 32'h1122CC44);
      chk("pw_we_cycles", snap + 1, we_cnt_a);
      p1_req = 1'b0;
      cyc();

      // be=0 write is a no-op
      snap = we_cnt_a;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'h0; p0_be = 4'h0;
      cyc();
      chk("be0_no_ack_yet", {31'd0, p0_ack_a}, 32'd0);
      cyc();
      chk("be0_ack", {31'd0, p0_ack_a}, 32'd1);
      chk("be0_we_cycles", snap, we_cnt_a);
      chk("be0_mem", mem_a[4], 32'hDEADBEEF);
      p0_req = 1'b0;
      cyc();

      // Port 0 holds req through its ack: no grant in the ack cycle
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20;
      cyc();
      cyc();
      chk("hold_ack1", {31'd0, p0_ack_a}, 32'd1);
      chk("hold_idle_in_ack", {31'd0, busy_a}, 32'd0);
      cyc();
      chk("hold_ack_drop", {31'd0, p0_ack_a}, 32'd0);
      chk("hold_no_regrant", {31'd0, busy_a}, 32'd0);
      cyc();
      chk("hold_regrant", {31'd0, busy_a}, 32'd1);
      cyc();
      chk("hold_ack2", {31'd0, p0_ack_a}, 32'd1);
      chk("hold_rdata", p0_rdata_a, 32'h1122CC44);
      p0_req = 1'b0;
      cyc();

      // Both ports read continuously; last grant was port 0
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk($sformatf("rr_a_p0_ack_%0d", k), {31'd0, p0_ack_a}, {31'd0, (k == 4) || (k == 8)});
         chk($sformatf("rr_a_p1_ack_%0d", k), {31'd0, p1_ack_a}, {31'd0, (k == 2) || (k == 6)});
         chk($sformatf("pr_b_p0_ack_%0d", k), {31'd0, p0_ack_b}, {31'd0, (k % 4) == 2});
         chk($sformatf("pr_b_p1_ack_%0d", k), {31'd0, p1_ack_b}, {31'd0, (k % 4) == 0});
      end
      chk("rr_p0_rdata", p0_rdata_a, 32'hDEADBEEF);
      chk("rr_p1_rdata", p1_rdata_a, 32'h1122CC44);
      idle_inputs();
      cyc();
      cyc();

      // Reset asserted while in MERGE with the write strobe high
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h000000EE; p1_be = 4'b0001;
      cyc();
      cyc();
      chk("mrst_pre_we", {31'd0, mem_we_a}, 32'd1);
      #1;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk("mrst_we_a", {31'd0, mem_we_a}, 32'd0);
      chk("mrst_we_b", {31'd0, mem_we_b}, 32'd0);
      chk("mrst_busy", {31'd0, busy_a}, 32'd0);
      chk("mrst_p0_ack", {31'd0, p0_ack_a}, 32'd0);
      chk("mrst_p1_ack", {31'd0, p1_ack_a}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("mrst_idle", {31'd0, busy_a}, 32'd0);
      chk("mrst_mem_a", mem_a[8], 32'h1122CC44);
      chk("mrst_mem_b", mem_b[8], 32'h1122CC44);

      // First tie after reset goes to port 0 even in round-robin mode
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
      cyc();
      cyc();
      chk("tie_p0_ack", {31'd0, p0_ack_a}, 32'd1);
      chk("tie_p1_ack", {31'd0, p1_ack_a}, 32'd0);
      idle_inputs();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
